// File: rtl/scoreboard_register_file.sv
// Integer register file with a per-register pending-write scoreboard.
// Combinational read ports bypass same-cycle writeback data; a saturating
// counter per register tracks outstanding writes so decode can stall on RAW.
module scoreboard_register_file #(
  parameter int          ADDR_WIDTH = 5,
  parameter int          DATA_WIDTH = 64,
  parameter int          NUM_READ   = 2,
  parameter int          CNT_WIDTH  = 2,
  parameter logic [63:0] RESET_FILL = 64'hDEADBEEFDEADBEEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          stackptr,
  input  logic [NUM_READ-1:0]            rd_en,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]            rd_ready,
  output logic                           raw_dependency,
  input  logic                           issue_valid,
  input  logic [ADDR_WIDTH-1:0]          issue_rd,
  output logic                           issue_ready,
  input  logic                           wb_valid,
  input  logic [ADDR_WIDTH-1:0]          wb_addr,
  input  logic [DATA_WIDTH-1:0]          wb_data,
  output logic                           write_complete,
  input  logic                           flush,
  output logic                           wb_underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [CNT_WIDTH-1:0]  cnt_q  [DEPTH];
  logic [CNT_WIDTH-1:0]  cnt_d  [DEPTH];
  logic                  write_complete_q, write_complete_d;
  logic                  wb_underflow_q, wb_underflow_d;

  logic wb_hit;
  logic claim_ok;
  logic claim_wb_same;

  // x0 is hardwired, so writebacks and claims to it have no effect
  assign wb_hit        = wb_valid && (wb_addr != '0);
  assign claim_ok      = issue_valid && issue_ready && (issue_rd != '0) && !flush;
  assign claim_wb_same = claim_ok && wb_hit && (issue_rd == wb_addr);

  assign write_complete = write_complete_q;
  assign wb_underflow   = wb_underflow_q;

  // A full counter only blocks a claim if no writeback frees a slot this cycle
  always_comb begin
    issue_ready = (issue_rd == '0) || (cnt_q[issue_rd] != CNT_MAX) ||
                  (wb_hit && (wb_addr == issue_rd));
  end

  // Read ports: bypass in-flight writeback data; ready when the only pending write lands now
  for (genvar p = 0; p < NUM_READ; p++) begin : g_read
    logic [ADDR_WIDTH-1:0] ra;
    logic                  byp;
    assign ra  = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign byp = wb_hit && (wb_addr == ra);
    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = (ra == '0) ? '0 :
                                                 byp ? wb_data : regs_q[ra];
    assign rd_ready[p] = (ra == '0) || (cnt_q[ra] == '0) ||
                         (byp && (cnt_q[ra] == CNT_ONE));
  end

  assign raw_dependency = |(rd_en & ~rd_ready);

  // Next-state for storage, pending counters and status flags
  always_comb begin
    regs_d           = regs_q;
    cnt_d            = cnt_q;
    write_complete_d = wb_hit;
    wb_underflow_d   = wb_underflow_q;
    if (wb_hit) begin
      regs_d[wb_addr] = wb_data;
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      if (!claim_wb_same) begin
        if (wb_hit && (cnt_q[wb_addr] != '0)) begin
          cnt_d[wb_addr] = cnt_q[wb_addr] - CNT_ONE;
        end
        if (claim_ok) begin
          cnt_d[issue_rd] = cnt_q[issue_rd] + CNT_ONE;
        end
      end
      if (wb_hit && (cnt_q[wb_addr] == '0)) begin
        wb_underflow_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset; x2 takes the stack pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == 0) begin
          regs_q[i] <= '0;
        end else if (i == 2) begin
          regs_q[i] <= stackptr;
        end else begin
          regs_q[i] <= DATA_WIDTH'(RESET_FILL);
        end
        cnt_q[i] <= '0;
      end
      write_complete_q <= 1'b0;
      wb_underflow_q   <= 1'b0;
    end else begin
      regs_q           <= regs_d;
      cnt_q            <= cnt_d;
      write_complete_q <= write_complete_d;
      wb_underflow_q   <= wb_underflow_d;
    end
  end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Scoreboard bench for scoreboard_register_file with three read ports.
// Stimulus pushes hand-computed expectations; a monitor pops and compares.
module tb_scoreboard_register_file;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 3;
  localparam logic [63:0] FILL = 64'hDEADBEEFDEADBEEF;
  localparam logic [63:0] SP   = 64'h8000_0000;

  localparam int K_RD0 = 0, K_RD1 = 1, K_RD2 = 2, K_RDY = 3, K_RAW = 4,
                 K_IRDY = 5, K_WC = 6, K_UF = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic [DW-1:0]     stackptr;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_ready;
  logic              raw_dependency;
  logic              issue_valid;
  logic [AW-1:0]     issue_rd;
  logic              issue_ready;
  logic              wb_valid;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic              write_complete;
  logic              flush;
  logic              wb_underflow;

  typedef struct {
    string       name;
    int          kind;
    logic [63:0] exp;
  } chk_t;

  chk_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  event sampleEv;

  scoreboard_register_file #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .CNT_WIDTH(2),
    .RESET_FILL(FILL)
  ) dut (
    .clk(clk), .reset(reset), .stackptr(stackptr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .raw_dependency(raw_dependency),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .write_complete(write_complete), .flush(flush), .wb_underflow(wb_underflow)
  );

  always #5 clk = ~clk;

  // Monitor: once a cycle's expectations are posted, compare against the live outputs
  function automatic logic [63:0] actualOf(int kind);
    case (kind)
      K_RD0:   return rd_data[0*DW +: DW];
      K_RD1:   return rd_data[1*DW +: DW];
      K_RD2:   return rd_data[2*DW +: DW];
      K_RDY:   return {61'b0, rd_ready};
      K_RAW:   return {63'b0, raw_dependency};
      K_IRDY:  return {63'b0, issue_ready};
      K_WC:    return {63'b0, write_complete};
      default: return {63'b0, wb_underflow};
    endcase
  endfunction

  initial begin
    forever begin
      @(sampleEv);
      #1;
      while (expQ.size() > 0) begin
        chk_t c;
        logic [63:0] act;
        c = expQ.pop_front();
        act = actualOf(c.kind);
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("[TB] FAIL %s: got %h, expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic applyStimulus(input logic iv, input logic [AW-1:0] ird,
                               input logic wv, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic fl,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [AW-1:0] a2, input logic [NR-1:0] en);
    @(negedge clk);
    issue_valid = iv;
    issue_rd    = ird;
    wb_valid    = wv;
    wb_addr     = wa;
    wb_data     = wd;
    flush       = fl;
    rd_addr     = {a2, a1, a0};
    rd_en       = en;
  endtask

  task automatic checkOutput(input string name, input int kind, input logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.exp  = exp;
    expQ.push_back(c);
  endtask

  task automatic post();
    ->sampleEv;
  endtask

  // Directed stimulus; each cycle drives inputs then posts its expected outputs
  initial begin
    reset = 1'b1;
    stackptr = SP;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    reset = 1'b0;

    // Reset values
    applyStimulus(0, 0, 0, 0, 0, 0, 5'd2, 5'd5, 5'd0, 3'b111);
    checkOutput("rst_x2", K_RD0, SP);
    checkOutput("rst_x5", K_RD1, FILL);
    checkOutput("rst_x0", K_RD2, 64'h0);
    checkOutput("rst_ready", K_RDY, 64'h7);
    checkOutput("rst_raw", K_RAW, 64'h0);
    checkOutput("rst_wc", K_WC, 64'h0);
    checkOutput("rst_uf", K_UF, 64'h0);
    checkOutput("rst_issue_rdy_x0", K_IRDY, 64'h1);
    post();

    // Claim x7, then observe the RAW stall and the bypass release
    applyStimulus(1, 5'd7, 0, 0, 0, 0, 5'd2, 5'd5, 5'd0, 3'b111);
    checkOutput("claim_x7_rdy", K_IRDY, 64'h1);
    post();
    applyStimulus(0, 5'd7, 0, 0, 0, 0, 5'd7, 5'd5, 5'd0, 3'b001);
    checkOutput("x7_pending_ready", K_RDY, 64'h6);
    checkOutput("x7_pending_raw", K_RAW, 64'h1);
    checkOutput("x7_pending_data", K_RD0, FILL);
    post();
    applyStimulus(0, 5'd7, 1, 5'd7, 64'h1234, 0, 5'd7, 5'd5, 5'd0, 3'b001);
    checkOutput("x7_bypass_data", K_RD0, 64'h1234);
    checkOutput("x7_bypass_ready", K_RDY, 64'h7);
    checkOutput("x7_bypass_raw", K_RAW, 64'h0);
    post();
    applyStimulus(0, 5'd7, 0, 0, 0, 0, 5'd7, 5'd5, 5'd0, 3'b001);
    checkOutput("x7_wc_pulse", K_WC, 64'h1);
    checkOutput("x7_stored", K_RD0, 64'h1234);
    post();
    applyStimulus(0, 5'd7, 0, 0, 0, 0, 5'd7, 5'd5, 5'd0, 3'b001);
    checkOutput("x7_wc_low", K_WC, 64'h0);
    post();

    // Saturate x3, claim+writeback in one cycle, then drain
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 5'd3, 0, 0, 0, 0, 5'd3, 5'd5, 5'd0, 3'b001);
      checkOutput("x3_claim_rdy", K_IRDY, 64'h1);
      post();
    end
    applyStimulus(1, 5'd3, 0, 0, 0, 0, 5'd3, 5'd5, 5'd0, 3'b001);
    checkOutput("x3_full_rdy", K_IRDY, 64'h0);
    post();
    applyStimulus(1, 5'd3, 1, 5'd3, 64'hAAA, 0, 5'd3, 5'd5, 5'd0, 3'b001);
    checkOutput("x3_claim_wb_rdy", K_IRDY, 64'h1);
    post();
    applyStimulus(0, 5'd3, 0, 0, 0, 0, 5'd3, 5'd5, 5'd0, 3'b001);
    checkOutput("x3_still_full", K_IRDY, 64'h0);
    checkOutput("x3_pending_ready", K_RDY, 64'h6);
    checkOutput("x3_data_aaa", K_RD0, 64'hAAA);
    post();
    applyStimulus(0, 5'd3, 1, 5'd3, 64'h31, 0, 5'd3, 5'd5, 5'd0, 3'b001);
    checkOutput("x3_drain1_ready", K_RDY, 64'h6);
    checkOutput("x3_drain1_data", K_RD0, 64'h31);
    post();
    applyStimulus(0, 5'd3, 1, 5'd3, 64'h32, 0, 5'd3, 5'd5, 5'd0, 3'b001);
    checkOutput("x3_drain2_ready", K_RDY, 64'h6);
    checkOutput("x3_b2b_wc", K_WC, 64'h1);
    post();
    applyStimulus(0, 5'd3, 1, 5'd3, 64'h33, 0, 5'd3, 5'd5, 5'd0, 3'b001);
    checkOutput("x3_drain3_ready", K_RDY, 64'h7);
    checkOutput("x3_b2b_wc2", K_WC, 64'h1);
    post();
    applyStimulus(0, 5'd3, 0, 0, 0, 0, 5'd3, 5'd5, 5'd0, 3'b001);
    checkOutput("x3_idle_ready", K_RDY, 64'h7);
    checkOutput("x3_final_data", K_RD0, 64'h33);
    checkOutput("x3_no_underflow", K_UF, 64'h0);
    post();

    // x9 with one pending: claim and writeback together keep it pending
    applyStimulus(1, 5'd9, 0, 0, 0, 0, 5'd9, 5'd5, 5'd0, 3'b001);
    post();
    applyStimulus(1, 5'd9, 1, 5'd9, 64'h99, 0, 5'd9, 5'd5, 5'd0, 3'b001);
    checkOutput("x9_same_cycle_ready", K_RDY, 64'h7);
    checkOutput("x9_same_cycle_data", K_RD0, 64'h99);
    post();
    applyStimulus(0, 5'd9, 0, 0, 0, 0, 5'd9, 5'd5, 5'd0, 3'b001);
    checkOutput("x9_next_ready", K_RDY, 64'h6);
    checkOutput("x9_next_data", K_RD0, 64'h99);
    post();
    applyStimulus(0, 5'd9, 1, 5'd9, 64'h9A, 0, 5'd9, 5'd5, 5'd0, 3'b001);
    checkOutput("x9_release_ready", K_RDY, 64'h7);
    post();

    // Flush clears x4 and x6 and wins over a same-cycle claim of x5
    applyStimulus(1, 5'd4, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 3'b000);
    post();
    applyStimulus(1, 5'd6, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 3'b000);
    post();
    applyStimulus(0, 5'd6, 0, 0, 0, 0, 5'd4, 5'd6, 5'd0, 3'b111);
    checkOutput("pre_flush_ready", K_RDY, 64'h4);
    checkOutput("pre_flush_raw", K_RAW, 64'h1);
    post();
    applyStimulus(1, 5'd5, 0, 0, 0, 1, 5'd4, 5'd6, 5'd0, 3'b111);
    post();
    applyStimulus(0, 5'd5, 0, 0, 0, 0, 5'd4, 5'd6, 5'd5, 3'b111);
    checkOutput("post_flush_ready", K_RDY, 64'h7);
    checkOutput("post_flush_raw", K_RAW, 64'h0);
    post();
    applyStimulus(0, 5'd5, 1, 5'd4, 64'h44, 0, 5'd4, 5'd6, 5'd5, 3'b111);
    checkOutput("uf_before_edge", K_UF, 64'h0);
    post();
    applyStimulus(0, 5'd5, 0, 0, 0, 0, 5'd4, 5'd6, 5'd5, 3'b111);
    checkOutput("uf_set", K_UF, 64'h1);
    checkOutput("uf_data_written", K_RD0, 64'h44);
    post();
    applyStimulus(0, 5'd5, 0, 0, 0, 0, 5'd4, 5'd6, 5'd5, 3'b111);
    checkOutput("uf_sticky", K_UF, 64'h1);
    post();

    // x0 ignores writes; enabled-port gating of raw_dependency with x7 pending
    applyStimulus(1, 5'd0, 1, 5'd0, 64'hFF, 0, 5'd0, 5'd0, 5'd0, 3'b000);
    checkOutput("x0_issue_rdy", K_IRDY, 64'h1);
    checkOutput("x0_no_bypass", K_RD0, 64'h0);
    post();
    applyStimulus(1, 5'd7, 0, 0, 0, 0, 5'd0, 5'd2, 5'd7, 3'b011);
    checkOutput("x0_after_wb", K_RD0, 64'h0);
    post();
    applyStimulus(0, 5'd7, 0, 0, 0, 0, 5'd0, 5'd2, 5'd7, 3'b011);
    checkOutput("gated_ready", K_RDY, 64'h3);
    checkOutput("gated_raw", K_RAW, 64'h0);
    checkOutput("gated_x2", K_RD1, SP);
    post();
    applyStimulus(0, 5'd7, 0, 0, 0, 0, 5'd0, 5'd2, 5'd7, 3'b111);
    checkOutput("ungated_raw", K_RAW, 64'h1);
    post();

    // Reset mid-operation discards pending state and restores contents
    reset = 1'b1;
    applyStimulus(0, 5'd0, 0, 0, 0, 0, 5'd7, 5'd4, 5'd2, 3'b111);
    reset = 1'b0;
    applyStimulus(0, 5'd0, 0, 0, 0, 0, 5'd7, 5'd4, 5'd2, 3'b111);
    checkOutput("rst2_ready", K_RDY, 64'h7);
    checkOutput("rst2_raw", K_RAW, 64'h0);
    checkOutput("rst2_x7", K_RD0, FILL);
    checkOutput("rst2_x4", K_RD1, FILL);
    checkOutput("rst2_x2", K_RD2, SP);
    checkOutput("rst2_uf", K_UF, 64'h0);
    checkOutput("rst2_wc", K_WC, 64'h0);
    post();

    #20;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run can never hang
  initial begin
    #50000;
    $display("[TB] FAIL timeout: got no finish, expected finish before limit");
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/scoreboard_register_file.md
# scoreboard_register_file

Parametrised integer register file with an integrated per-register pending-write scoreboard, built for the decode/writeback stage of the pipelined core. Provides NUM_READ combinational read ports with same-cycle writeback bypass. A saturating pending counter per register allows several in-flight writes to the same destination. A flush input discards all pending state on redirect. Decode stalls on `raw_dependency`; writeback drives the write port.

## Interface
- `ADDR_WIDTH`, 5: register index width; depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, 64: register width.
- `NUM_READ`, 2: number of read ports, 1..4.
- `CNT_WIDTH`, 2: pending-counter width; max outstanding writes per register = 2^CNT_WIDTH-1.
- `RESET_FILL`, 64'hDEADBEEFDEADBEEF: reset value of all registers except x0 and x2 (truncated to DATA_WIDTH).
- `clk` in 1: the single clock; everything is sampled on its rising edge.
- `reset` in 1: synchronous, active-high.
- `stackptr` in DATA_WIDTH: value loaded into x2 at reset.
- `rd_en` in NUM_READ: per-port read request; only enabled ports contribute to `raw_dependency`.
- `rd_addr` in NUM_READ*ADDR_WIDTH: read indices, port p at bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- `rd_data` out NUM_READ*DATA_WIDTH: read data, same packing.
- `rd_ready` out NUM_READ: per port, 1 = `rd_data` is architecturally current.
- `raw_dependency` out 1: OR over p of (rd_en[p] & ~rd_ready[p]).
- `issue_valid` in 1: decode claims destination `issue_rd`.
- `issue_rd` in ADDR_WIDTH: destination being claimed.
- `issue_ready` out 1: claim can be accepted this cycle.
- `wb_valid` in 1: writeback request.
- `wb_addr` in ADDR_WIDTH: writeback index.
- `wb_data` in DATA_WIDTH: writeback data.
- `write_complete` out 1: registered pulse, 1 the cycle after an accepted `wb_valid`.
- `flush` in 1: clear all pending counters.
- `wb_underflow` out 1: sticky; set on writeback to a nonzero register whose counter is 0.

## Operation
- Storage: 2^ADDR_WIDTH x DATA_WIDTH registers plus a CNT_WIDTH counter per register.
- x0 always reads 0 and always has rd_ready=1. Writes and claims to x0 are ignored; `issue_ready` is 1 for x0.
- Reset:
  - x2 <= stackptr; x0 = 0; all other registers <= RESET_FILL.
  - All counters <= 0; `write_complete` <= 0; `wb_underflow` <= 0.
- Claim: accepted when issue_valid & issue_ready & issue_rd != 0; increments cnt[issue_rd].
- `issue_ready` = 0 only when cnt[issue_rd] is at maximum (all ones) and the same cycle has no writeback to that register that would decrement it.
- Writeback: when wb_valid & wb_addr != 0:
  - reg[wb_addr] <= wb_data.
  - cnt[wb_addr] decrements, saturating at 0.
  - If the counter was already 0, the data is still written and `wb_underflow` is set.
- Claim and writeback to the same register in the same cycle: the counter is unchanged and the data is written.
- Flush: all counters <= 0 at the edge. Flush has priority over claims in the same cycle. A writeback in the same cycle still writes its data and does not set `wb_underflow`.
- Read port p, with a = rd_addr[p]:
  - Bypass: if wb_valid & wb_addr == a & a != 0, rd_data = wb_data; otherwise rd_data = reg[a].
  - rd_ready = 1 if cnt[a] == 0.
  - rd_ready = 1 if the bypass hits and cnt[a] == 1; this holds even with a same-cycle claim to a.
  - rd_ready = 0 otherwise.
- `rd_data` is driven to the register value even when rd_ready = 0; it is never left undriven.

## Timing
- Reads, `rd_ready`, `raw_dependency` and `issue_ready` are combinational from current state and same-cycle writeback inputs. Latency is 0.
- Register contents and counters update at the rising edge. A read in cycle N+1 sees a write from cycle N.
- `write_complete` is high for exactly one cycle after each accepted writeback. Back-to-back writebacks give a continuous high.
- Reset mid-operation: in-flight claims are discarded and all outputs take their reset values at the edge. `rd_ready` is all ones after reset.
- There is no handshake on the read ports. The stall decision is made by decode alone.

## Test plan
- Reset with stackptr=64'h8000_0000 → x2 reads 64'h8000_0000, x5 reads 64'hDEADBEEFDEADBEEF, x0 reads 0, rd_ready all 1, write_complete 0.
- Claim x7, next cycle read x7 → rd_ready[0]=0, raw_dependency=1. Writeback x7=64'h1234 → same-cycle rd_data=64'h1234 with rd_ready=1. Next cycle: write_complete=1.
- Claim x3 three times (CNT_WIDTH=2) → fourth claim has issue_ready=0. Writeback x3 plus claim x3 in the same cycle → claim accepted, counter stays at 3. Three writebacks → counter returns to 0.
- Same-cycle claim and writeback to x9 with cnt=1 → data written, cnt stays 1, rd_ready for x9 in the next cycle = 0.
- Claim x4 and x6, then flush → both ready next cycle. Later writeback to x4 → data written, wb_underflow=1 and stays 1 until reset.
- NUM_READ=3: ports read x0/x2/x7 with only x7 pending and rd_en=3'b011 → raw_dependency=0. With rd_en=3'b111 → raw_dependency=1.
